// File: rtl/output_fifo.sv
// Output queue between the CPU OUT port and the host result collector.
// Optional running checksum of accepted pushes when OUTPUT_FIFO_CHECKSUM_EN is defined.
module output_fifo #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              out_write,
    input  logic [DATA_W-1:0] out_data,
    output logic              out_full,
    input  logic              clear,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              overflow
`ifdef OUTPUT_FIFO_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   s_count;
    logic [ADDR_W:0]   s_count_nxt;
    logic              push_ok;
    logic              load;

    // Read handshake: a word transfers on an edge where rd_valid=1 and rd_ready=1;
    // rd_data stays stable while rd_valid=1 and rd_ready=0, rd_ready is ignored while rd_valid=0.
    assign push_ok = out_write && !out_full;
    assign load    = (s_count != '0) && (!rd_valid || rd_ready);

    always_comb begin
        s_count_nxt = s_count;
        case ({push_ok, load})
            2'b10:   s_count_nxt = s_count + 1'b1;
            2'b01:   s_count_nxt = s_count - 1'b1;
            default: s_count_nxt = s_count;
        endcase
    end

    // Storage is never reset; only pointers and flags are.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= out_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            s_count  <= '0;
            out_full <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            s_count  <= '0;
            out_full <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // A push seen while full is dropped even if this edge frees a slot.
            if (out_write && out_full) begin
                overflow <= 1'b1;
            end
            if (load) begin
                rd_data  <= mem[rd_ptr];
                rd_valid <= 1'b1;
                rd_ptr   <= rd_ptr + 1'b1;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
            s_count  <= s_count_nxt;
            out_full <= (s_count_nxt == FULL_CNT);
        end
    end

    assign count = s_count + {{ADDR_W{1'b0}}, rd_valid};

`ifdef OUTPUT_FIFO_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (clear) begin
            checksum <= '0;
        end else if (push_ok) begin
            checksum <= checksum + out_data;
        end
    end
`endif

endmodule

// File: tb/tb_output_fifo.sv
// Bench for output_fifo with a 4-deep storage; expected words travel through exp_q.
// Directed steps plus a short random phase, all in one initial block.
module tb_output_fifo;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              out_write;
  logic [DATA_W-1:0] out_data;
  logic              out_full;
  logic              clear;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;
  logic [ADDR_W:0]   count;
  logic              overflow;
`ifdef OUTPUT_FIFO_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  output_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .out_write (out_write),
    .out_data  (out_data),
    .out_full  (out_full),
    .clear     (clear),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .count     (count),
    .overflow  (overflow)
`ifdef OUTPUT_FIFO_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and reference state
  logic [DATA_W-1:0] exp_q[$];
  int                m_sc;
  logic              m_v;
  logic              m_ov;
  logic [DATA_W-1:0] m_sum;
  int                checks;
  int                errors;
  int                pops;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_sc  = 0;
    m_v   = 1'b0;
    m_ov  = 1'b0;
    m_sum = '0;
  endtask

  task automatic check_state();
    chk("count", 32'(count), 32'(m_sc + int'(m_v)));
    chk("rd_valid", 32'(rd_valid), 32'(m_v));
    chk("out_full", 32'(out_full), 32'(m_sc == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ov));
`ifdef OUTPUT_FIFO_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'(m_sum));
`endif
  endtask

  // One clock: drive, sample handshake at negedge, advance model, check after edge.
  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic rdy, input logic clr);
    logic p;
    logic ld;
    logic [DATA_W-1:0] e;
    out_write = w;
    out_data  = d;
    rd_ready  = rdy;
    clear     = clr;
    @(negedge clk);
    if (clr) begin
      model_reset();
    end else begin
      if (rd_valid && rdy) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          pops++;
          chk("pop_data", 32'(rd_data), 32'(e));
        end
      end
      p  = w && (m_sc != DEPTH);
      ld = (m_sc != 0) && (!m_v || rdy);
      if (w && !p) m_ov = 1'b1;
      if (p) begin
        exp_q.push_back(d);
        m_sum = m_sum + d;
      end
      m_sc = m_sc + int'(p) - int'(ld);
      if (ld) m_v = 1'b1;
      else if (rdy) m_v = 1'b0;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (rd_valid || m_sc != 0) begin
      if (n == 20) begin
        chk({tag, "_drain_timeout"}, 32'(n), 32'd0);
        break;
      end
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_count_zero"}, 32'(count), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pops      = 0;
    rst       = 1'b1;
    out_write = 1'b0;
    out_data  = '0;
    rd_ready  = 1'b0;
    clear     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_out_full", 32'(out_full), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);

    // Two-edge latency of a single word
    step(1'b1, 12'h123, 1'b0, 1'b0);
    chk("lat_not_yet_valid", 32'(rd_valid), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("lat_valid", 32'(rd_valid), 32'd1);
    chk("lat_data", 32'(rd_data), 32'h123);
    chk("lat_count", 32'(count), 32'd1);
    drain("single");

    // Five words held, then released back to back
    for (int i = 1; i <= 5; i++) step(1'b1, 12'(i), 1'b0, 1'b0);
    chk("hold5_count", 32'(count), 32'd5);
    chk("hold5_head", 32'(rd_data), 32'h001);
    pops = 0;
    drain("hold5");
    chk("hold5_pops", 32'(pops), 32'd5);

    // Overfill: seven pushes, only five fit
    for (int i = 1; i <= 7; i++) step(1'b1, 12'h100 + 12'(i), 1'b0, 1'b0);
    chk("over_count", 32'(count), 32'd5);
    chk("over_full", 32'(out_full), 32'd1);
    chk("over_flag", 32'(overflow), 32'd1);
    pops = 0;
    drain("over");
    chk("over_pops", 32'(pops), 32'd5);
    chk("over_sticky", 32'(overflow), 32'd1);

    // Sustained push and pop across pointer wrap
    pops = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 12'(i * 7 + 3), 1'b1, 1'b0);
      checks++;
      assert (count <= 2) else begin
        errors++;
        $error("FAIL stream_count_bound: observed %0d expected <=2", count);
      end
    end
    drain("stream");
    chk("stream_pops", 32'(pops), 32'd100);

    // Clear with words held and a push on the same edge
    for (int i = 0; i < 3; i++) step(1'b1, 12'h200 + 12'(i), 1'b0, 1'b0);
    step(1'b1, 12'hABC, 1'b0, 1'b1);
    chk("clear_rd_valid", 32'(rd_valid), 32'd0);
    chk("clear_rd_data", 32'(rd_data), 32'd0);
    chk("clear_count", 32'(count), 32'd0);
    chk("clear_overflow", 32'(overflow), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("clear_push_discarded", 32'(count), 32'd0);

`ifdef OUTPUT_FIFO_CHECKSUM_EN
    step(1'b1, 12'hFFF, 1'b0, 1'b0);
    step(1'b1, 12'h002, 1'b0, 1'b0);
    chk("cks_wrap", 32'(checksum), 32'h001);
    for (int i = 0; i < 3; i++) step(1'b1, 12'h010, 1'b0, 1'b0);
    chk("cks_full", 32'(checksum), 32'h031);
    step(1'b1, 12'h555, 1'b0, 1'b0);
    chk("cks_dropped", 32'(checksum), 32'h031);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("cks_clear", 32'(checksum), 32'h000);
`endif

    // Random traffic with occasional clears
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end
    drain("random");

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 3; i++) step(1'b1, 12'h300 + 12'(i), 1'b0, 1'b0);
    step(1'b1, 12'h3FF, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    chk("arst_rd_data", 32'(rd_data), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_full", 32'(out_full), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    model_reset();
    out_write = 1'b0;
    rd_ready  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 12'h456, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_data", 32'(rd_data), 32'h456);
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
